// File: rtl/fft_frame_sequencer.sv
// Purpose: loads one windowed frame into the FFT input buffer, zero-pads it to NFFT, starts the FFT and supervises its bin stream.
// Latency: buffer writes are registered one cycle after the LOAD handshake or PAD cycle; start pulse comes NFFT+2 cycles after enable (continuous input).
// Backpressure: s_ready_o is high only in LOAD, so upstream is held off while padding, running the FFT or idle.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   enable_i                         lets a new frame begin (looked at in IDLE only)
//   s_valid_i/s_ready_o/s_sample_i   windowed sample stream from the framing stage
//   fft_in_valid_o/fft_frame_ptr_o/fft_real_o   FFT input buffer write port
//   fft_start_o, fft_done_i          FFT start pulse and completion pulse
//   fft_power_valid_i/fft_power_ptr_i   power-bin strobe and index from the FFT
//   busy_o, frames_done_o            status: not idle, completed-frame count
//   err_timeout_o, err_bin_o, clear_err_i   sticky error flags and their clear
module fft_frame_sequencer #(
    parameter int NFFT            = 512,
    parameter int INPUT_WIDTH     = 16,
    parameter int FRAME_SIZE      = 306,
    parameter int NUM_BINS        = 257,
    parameter int WATCHDOG_CYCLES = 1048575
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable_i,
    input  logic                          s_valid_i,
    output logic                          s_ready_o,
    input  logic signed [INPUT_WIDTH-1:0] s_sample_i,
    output logic                          fft_in_valid_o,
    output logic [$clog2(NFFT)-1:0]       fft_frame_ptr_o,
    output logic signed [INPUT_WIDTH-1:0] fft_real_o,
    output logic                          fft_start_o,
    input  logic                          fft_done_i,
    input  logic                          fft_power_valid_i,
    input  logic [$clog2(NFFT)-1:0]       fft_power_ptr_i,
    output logic                          busy_o,
    output logic [15:0]                   frames_done_o,
    output logic                          err_timeout_o,
    output logic                          err_bin_o,
    input  logic                          clear_err_i
);

    localparam int PW = $clog2(NFFT);
    // One extra bit so the pointer can count a full NFFT-sample frame without wrapping.
    localparam int CW = PW + 1;
    // Bin counter saturates at NUM_BINS+1 so "too many bins" never aliases to a legal count.
    localparam int BW = $clog2(NUM_BINS + 2);
    localparam int WW = $clog2(WATCHDOG_CYCLES + 1);

    localparam logic [CW-1:0] LAST_SAMPLE = CW'(FRAME_SIZE - 1);
    localparam logic [CW-1:0] LAST_PAD    = CW'(NFFT - 1);
    localparam logic [BW-1:0] BIN_FULL    = BW'(NUM_BINS);
    localparam logic [WW:0]   WD_LIMIT    = (WW + 1)'(WATCHDOG_CYCLES);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        PAD  = 3'd2,
        KICK = 3'd3,
        RUN  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wr_ptr;
    logic [BW-1:0] bin_cnt, bin_cnt_nxt;
    logic [WW-1:0] wd_cnt;
    logic [15:0]   frame_cnt;

    logic in_run, hs, last_load, last_pad, wd_hit;
    logic bin_viol, done_bad, stray, set_bin, set_to;

    assign in_run    = (state_q == RUN);
    assign hs        = s_valid_i && (state_q == LOAD);
    assign last_load = hs && (wr_ptr == LAST_SAMPLE);
    assign last_pad  = (wr_ptr == LAST_PAD);
    // wd_cnt holds completed RUN cycles, so +1 is the count including the current cycle.
    assign wd_hit    = in_run && (({1'b0, wd_cnt} + 1'b1) == WD_LIMIT);

    always_comb begin
        bin_cnt_nxt = bin_cnt;
        if (fft_power_valid_i && (bin_cnt <= BIN_FULL)) begin
            bin_cnt_nxt = bin_cnt + 1'b1;
        end
    end

    assign bin_viol = in_run && fft_power_valid_i &&
                      ((bin_cnt >= BIN_FULL) || (32'(fft_power_ptr_i) != 32'(bin_cnt)));
    assign done_bad = in_run && fft_done_i && (bin_cnt_nxt != BIN_FULL);
    assign stray    = !in_run && (fft_power_valid_i || fft_done_i);
    assign set_bin  = bin_viol || done_bad || stray;
    // A done pulse arriving on the watchdog's last cycle still completes the frame.
    assign set_to   = wd_hit && !fft_done_i;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (enable_i) state_d = LOAD;
            LOAD: if (last_load) state_d = (FRAME_SIZE == NFFT) ? KICK : PAD;
            PAD:  if (last_pad) state_d = KICK;
            KICK: state_d = RUN;
            RUN:  if (fft_done_i || wd_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        s_ready_o = (state_q == LOAD);
        busy_o    = (state_q != IDLE);
    end

    // Datapath, counters and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr          <= '0;
            bin_cnt         <= '0;
            wd_cnt          <= '0;
            frame_cnt       <= '0;
            fft_in_valid_o  <= 1'b0;
            fft_frame_ptr_o <= '0;
            fft_real_o      <= '0;
            fft_start_o     <= 1'b0;
            err_timeout_o   <= 1'b0;
            err_bin_o       <= 1'b0;
        end else begin
            fft_in_valid_o <= 1'b0;
            fft_start_o    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable_i) wr_ptr <= '0;
                end
                LOAD: begin
                    if (hs) begin
                        fft_in_valid_o  <= 1'b1;
                        fft_frame_ptr_o <= wr_ptr[PW-1:0];
                        fft_real_o      <= s_sample_i;
                        wr_ptr          <= wr_ptr + 1'b1;
                    end
                end
                PAD: begin
                    // The FFT buffer keeps stale data, so every tail slot is rewritten with zero.
                    fft_in_valid_o  <= 1'b1;
                    fft_frame_ptr_o <= wr_ptr[PW-1:0];
                    fft_real_o      <= '0;
                    wr_ptr          <= wr_ptr + 1'b1;
                end
                KICK: begin
                    fft_start_o <= 1'b1;
                    wd_cnt      <= '0;
                    bin_cnt     <= '0;
                end
                RUN: begin
                    wd_cnt  <= wd_cnt + 1'b1;
                    bin_cnt <= bin_cnt_nxt;
                    if (fft_done_i) frame_cnt <= frame_cnt + 1'b1;
                end
                default: ;
            endcase
            // A new error in the same cycle as the clear keeps the flag set.
            err_bin_o     <= set_bin || (err_bin_o && !clear_err_i);
            err_timeout_o <= set_to || (err_timeout_o && !clear_err_i);
        end
    end

    assign frames_done_o = frame_cnt;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Bench for fft_frame_sequencer: random sample streams and an FFT bin/done model, compared
// against expected buffer contents, start timing, frame counts and error flags.
module tb_fft_frame_sequencer;

    localparam int NFFT  = 512;
    localparam int IW    = 16;
    localparam int FRAME = 306;
    localparam int BINS  = 257;
    localparam int WD    = 300;
    localparam int PW    = $clog2(NFFT);

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 enable_i = 1'b0;
    logic                 s_valid_i = 1'b0;
    logic                 s_ready_o;
    logic signed [IW-1:0] s_sample_i = '0;
    logic                 fft_in_valid_o;
    logic [PW-1:0]        fft_frame_ptr_o;
    logic signed [IW-1:0] fft_real_o;
    logic                 fft_start_o;
    logic                 fft_done_i = 1'b0;
    logic                 fft_power_valid_i = 1'b0;
    logic [PW-1:0]        fft_power_ptr_i = '0;
    logic                 busy_o;
    logic [15:0]          frames_done_o;
    logic                 err_timeout_o;
    logic                 err_bin_o;
    logic                 clear_err_i = 1'b0;

    fft_frame_sequencer #(
        .NFFT(NFFT), .INPUT_WIDTH(IW), .FRAME_SIZE(FRAME),
        .NUM_BINS(BINS), .WATCHDOG_CYCLES(WD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_sample_i(s_sample_i),
        .fft_in_valid_o(fft_in_valid_o), .fft_frame_ptr_o(fft_frame_ptr_o),
        .fft_real_o(fft_real_o), .fft_start_o(fft_start_o), .fft_done_i(fft_done_i),
        .fft_power_valid_i(fft_power_valid_i), .fft_power_ptr_i(fft_power_ptr_i),
        .busy_o(busy_o), .frames_done_o(frames_done_o), .err_timeout_o(err_timeout_o),
        .err_bin_o(err_bin_o), .clear_err_i(clear_err_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed buffer writes and start pulses
    logic [PW+IW-1:0] act_q[$];
    int start_cnt = 0;
    always @(negedge clk) begin
        if (fft_in_valid_o) act_q.push_back({fft_frame_ptr_o, fft_real_o});
        if (fft_start_o) start_cnt++;
    end

    // Reference model state
    logic [15:0] exp_frames = '0;
    logic        exp_err_bin = 1'b0;
    logic        exp_err_to = 1'b0;
    int          exp_starts = 0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({s_ready_o, fft_in_valid_o, fft_frame_ptr_o, fft_real_o, fft_start_o,
                    busy_o, frames_done_o, err_timeout_o, err_bin_o});
    endfunction

    task automatic check_status(input string tag);
        check_val({tag, "_frames"}, frames_done_o, exp_frames);
        check_val({tag, "_err_bin"}, err_bin_o, exp_err_bin);
        check_val({tag, "_err_timeout"}, err_timeout_o, exp_err_to);
        check_val({tag, "_starts"}, start_cnt, exp_starts);
    endtask

    // mode: 0 = clean bin sequence, 1 = bin 5 repeated, 2 = FFT never finishes
    // abort_after >= 0 resets the DUT once that many samples have been accepted
    task automatic do_frame(input int pct, input int mode, input bit hold, input int abort_after);
        int n, acc, t0;
        bit bad;
        logic [IW-1:0]    exp_q[$];
        logic [PW-1:0]    bq[$];
        logic [PW+IW-1:0] ew;

        n = 0;
        while (busy_o && n < 4 * NFFT) begin
            @(negedge clk);
            n++;
        end
        check_val("idle_before_frame", busy_o, 0);
        act_q.delete();
        enable_i  = 1'b1;
        s_valid_i = 1'b0;
        t0 = cyc;

        acc = 0;
        n = 0;
        while (acc < FRAME && n < 20000) begin
            @(negedge clk);
            n++;
            if (!hold) enable_i = 1'b0;
            if (abort_after >= 0 && acc == abort_after) break;
            s_valid_i  = ($urandom_range(0, 99) < pct);
            s_sample_i = IW'($urandom);
            if (s_valid_i && s_ready_o) begin
                exp_q.push_back(s_sample_i);
                acc++;
            end
        end

        if (abort_after >= 0) begin
            rst_n     = 1'b0;
            s_valid_i = 1'b0;
            enable_i  = 1'b0;
            #1;
            check_val("outputs_after_midload_reset", all_outputs(), 0);
            exp_frames  = '0;
            exp_err_bin = 1'b0;
            exp_err_to  = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            return;
        end

        check_val("samples_accepted", acc, FRAME);
        @(negedge clk);
        s_valid_i = 1'b0;
        check_val("ready_drop_after_last", s_ready_o, 0);

        n = 0;
        while (!fft_start_o && n < 2 * NFFT) begin
            @(negedge clk);
            n++;
        end
        check_val("start_seen", fft_start_o, 1);
        if (pct == 100) check_val("start_latency", cyc - t0, NFFT + 2);
        exp_starts++;

        check_val("write_count", act_q.size(), NFFT);
        for (int i = 0; i < NFFT && i < act_q.size(); i++) begin
            if (i < FRAME) ew = {PW'(i), exp_q[i]};
            else           ew = {PW'(i), IW'(0)};
            check_val("buffer_write", act_q[i], ew);
        end

        if (mode != 2) begin
            for (int k = 0; k < BINS; k++) bq.push_back(PW'((mode == 1 && k > 5) ? k - 1 : k));
        end
        bad = (bq.size() != BINS);
        foreach (bq[k]) if (int'(bq[k]) != k || k >= BINS) bad = 1'b1;

        if (mode == 2) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (busy_o && n < WD + 50);
            check_val("timeout_run_cycles", n, WD);
            exp_err_to = 1'b1;
        end else begin
            foreach (bq[k]) begin
                @(negedge clk);
                fft_power_valid_i = 1'b1;
                fft_power_ptr_i   = bq[k];
            end
            @(negedge clk);
            fft_power_valid_i = 1'b0;
            fft_done_i        = 1'b1;
            @(negedge clk);
            fft_done_i = 1'b0;
            check_val("busy_after_done", busy_o, 0);
            if (bad) exp_err_bin = 1'b1;
            exp_frames = exp_frames + 16'd1;
        end
        check_status("frame_end");
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_val("outputs_in_reset", all_outputs(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("outputs_after_reset", all_outputs(), 0);

        // Nominal frame, continuous valid
        do_frame(100, 0, 1'b0, -1);
        // Bubbly input
        do_frame(50, 0, 1'b0, -1);
        // Duplicated bin 5
        do_frame(100, 1, 1'b0, -1);

        clear_err_i = 1'b1;
        @(negedge clk);
        clear_err_i = 1'b0;
        exp_err_bin = 1'b0;
        check_val("err_bin_cleared", err_bin_o, exp_err_bin);

        // Clear together with a stray strobe outside RUN: error wins
        clear_err_i       = 1'b1;
        fft_power_valid_i = 1'b1;
        @(negedge clk);
        clear_err_i       = 1'b0;
        fft_power_valid_i = 1'b0;
        exp_err_bin = 1'b1;
        check_val("err_bin_set_wins_clear", err_bin_o, exp_err_bin);
        check_status("after_stray");

        // Watchdog expiry
        do_frame(100, 2, 1'b0, -1);
        clear_err_i = 1'b1;
        @(negedge clk);
        clear_err_i = 1'b0;
        exp_err_bin = 1'b0;
        exp_err_to  = 1'b0;
        check_status("after_clear_all");

        // Reset after 100 accepted samples, then three back-to-back frames from pointer 0
        do_frame(100, 0, 1'b0, 100);
        check_status("after_midload_reset");
        do_frame(100, 0, 1'b1, -1);
        do_frame(70, 0, 1'b1, -1);
        do_frame(100, 0, 1'b0, -1);
        check_val("frames_after_back_to_back", frames_done_o, 16'd3);

        // Counter wrap from a preloaded 0xFFFF
        force dut.frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt;
        exp_frames = 16'hFFFF;
        check_val("frames_preload", frames_done_o, exp_frames);
        do_frame(100, 0, 1'b0, -1);
        check_val("frames_wrapped", frames_done_o, 16'h0000);

        repeat (3) @(negedge clk);
        check_val("no_stray_starts", start_cnt, exp_starts);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "bench time limit reached");
    end

endmodule
